// File: rtl/mmu_if.sv
// mmu_if: bus-side bundle for the address translation stage.
// Holds the 68000 cycle, map registers, page-table port and results.
`timescale 1ns/1ps
interface mmu_if;
    logic        as;
    logic [2:0]  fc;
    logic        write;
    logic [23:0] addr;
    logic [15:0] supervisor_map_1;
    logic [15:0] supervisor_map_2;
    logic [3:0]  user_map;
    logic        pt_we;
    logic [6:0]  pt_addr;
    logic [15:0] pt_wdata;
    logic        phys_valid;
    logic [27:0] phys_addr;
    logic        berr;
    logic        fault_valid;
    logic [23:0] fault_addr;
    logic        fault_clr;

    modport master (
        output as, fc, write, addr,
        output supervisor_map_1, supervisor_map_2, user_map,
        output pt_we, pt_addr, pt_wdata, fault_clr,
        input  phys_valid, phys_addr, berr,
        input  fault_valid, fault_addr
    );

    modport slave (
        input  as, fc, write, addr,
        input  supervisor_map_1, supervisor_map_2, user_map,
        input  pt_we, pt_addr, pt_wdata, fault_clr,
        output phys_valid, phys_addr, berr,
        output fault_valid, fault_addr
    );
endinterface

// File: rtl/mmu.sv
// mmu: 24-bit logical to 28-bit physical translation, fixed 2-clock latency.
// Optional MMU_WRITE_PROTECT_EN: user writes to entries with bit14=0 fault.
`timescale 1ns/1ps
module mmu (
    input logic  clk,
    input logic  reset_n,
    mmu_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOOKUP, ACTIVE, FAULT} state_t;

    state_t      state_q, state_d;
    logic        step_q, step_d;
    logic        sup_q, sup_d;
    logic        write_q, write_d;
    logic        win_q, win_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] smap_q, smap_d;
    logic        phys_valid_q, phys_valid_d;
    logic        berr_q, berr_d;
    logic [27:0] phys_addr_q, phys_addr_d;
    logic        fault_valid_q, fault_valid_d;
    logic [23:0] fault_addr_q, fault_addr_d;

    logic [15:0] pt_mem [128];
    logic [15:0] pt_rdata_q;
    logic [6:0]  pt_raddr;
    logic [15:0] entry;
    logic        fault;
    logic [27:0] xlat;
    logic        unused_bits;

    assign pt_raddr = {bus.user_map[2:0], bus.addr[23:20]};

    // page table: no reset; read only when a cycle is accepted so the entry holds
    always_ff @(posedge clk) begin
        if (bus.pt_we) begin
            pt_mem[bus.pt_addr] <= bus.pt_wdata;
        end
        if (state_q == IDLE && bus.as) begin
            pt_rdata_q <= pt_mem[pt_raddr];
        end
    end

    // translate the latched cycle against its latched map entry
    always_comb begin
        entry = sup_q ? smap_q : pt_rdata_q;
        fault = 1'b0;
        xlat  = {4'h0, addr_q};
        if (!sup_q || win_q) begin
            fault = !entry[15];
            xlat  = {entry[7:0], addr_q[19:0]};
        end
`ifdef MMU_WRITE_PROTECT_EN
        if (!sup_q && write_q && !entry[14]) begin
            fault = 1'b1;
        end
`endif
    end

    // state sequencing, output and fault-capture next values
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        sup_d         = sup_q;
        write_d       = write_q;
        win_d         = win_q;
        addr_d        = addr_q;
        smap_d        = smap_q;
        phys_valid_d  = phys_valid_q;
        berr_d        = berr_q;
        phys_addr_d   = phys_addr_q;
        fault_valid_d = fault_valid_q & ~bus.fault_clr;
        fault_addr_d  = fault_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.as) begin
                    state_d = LOOKUP;
                    step_d  = 1'b0;
                    addr_d  = bus.addr;
                    sup_d   = bus.fc[2];
                    write_d = bus.write;
                    win_d   = (bus.addr[23:21] == 3'b111);
                    smap_d  = bus.addr[20] ? bus.supervisor_map_2
                                           : bus.supervisor_map_1;
                end
            end
            LOOKUP: begin
                if (!step_q) begin
                    step_d = 1'b1;
                end else if (fault) begin
                    state_d     = FAULT;
                    berr_d      = 1'b1;
                    phys_addr_d = 28'h0;
                    if (!fault_valid_q || bus.fault_clr) begin
                        fault_valid_d = 1'b1;
                        fault_addr_d  = addr_q;
                    end
                end else begin
                    state_d      = ACTIVE;
                    phys_valid_d = 1'b1;
                    phys_addr_d  = xlat;
                end
            end
            ACTIVE, FAULT: begin
                if (!bus.as) begin
                    state_d      = IDLE;
                    phys_valid_d = 1'b0;
                    berr_d       = 1'b0;
                    phys_addr_d  = 28'h0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            step_q        <= 1'b0;
            sup_q         <= 1'b0;
            write_q       <= 1'b0;
            win_q         <= 1'b0;
            addr_q        <= 24'h0;
            smap_q        <= 16'h0;
            phys_valid_q  <= 1'b0;
            berr_q        <= 1'b0;
            phys_addr_q   <= 28'h0;
            fault_valid_q <= 1'b0;
            fault_addr_q  <= 24'h0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            sup_q         <= sup_d;
            write_q       <= write_d;
            win_q         <= win_d;
            addr_q        <= addr_d;
            smap_q        <= smap_d;
            phys_valid_q  <= phys_valid_d;
            berr_q        <= berr_d;
            phys_addr_q   <= phys_addr_d;
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign bus.phys_valid  = phys_valid_q;
    assign bus.berr        = berr_q;
    assign bus.phys_addr   = phys_addr_q;
    assign bus.fault_valid = fault_valid_q;
    assign bus.fault_addr  = fault_addr_q;

    assign unused_bits = &{1'b0, bus.fc[1:0], bus.user_map[3],
                           entry[14:8], write_q};

endmodule

// File: tb/tb_mmu.sv
// tb_mmu: randomized scoreboard bench for the mmu translation stage.
// Expected responses come from a rule-level model with its own page table.
`timescale 1ns/1ps
module tb_mmu;

    typedef struct {
        bit          err;
        logic [27:0] pa;
        bit          fv;
        logic [23:0] fa;
        int          due;
    } exp_t;

    logic clk;
    logic reset_n;
    mmu_if bus ();

    mmu u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        q[$];
    exp_t        cur;
    bit          prev_resp = 0;
    logic [15:0] pt [128];
    bit          m_fv = 0;
    logic [23:0] m_fa = 24'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // rule-level model: returns {err, phys_addr}
    function automatic logic [28:0] model(input bit sup, input bit wr,
                                          input logic [23:0] a,
                                          input logic [2:0] um);
        logic [15:0] ent;
        int          page;
        bit          err;
        bit          wp_en;
`ifdef MMU_WRITE_PROTECT_EN
        wp_en = 1;
`else
        wp_en = 0;
`endif
        page = int'(a[23:20]);
        if (sup && page < 14) return {1'b0, 4'h0, a};
        if (sup) ent = (page == 14) ? bus.supervisor_map_1
                                    : bus.supervisor_map_2;
        else     ent = pt[int'(um) * 16 + page];
        err = !ent[15] || (wp_en && !sup && wr && !ent[14]);
        if (err) return {1'b1, 28'h0};
        return {1'b0, 28'(ent[7:0]) * 28'h100000
                      + 28'(a % 24'h100000)};
    endfunction

    // monitor: pop on each new response, check hold while it lasts
    always @(negedge clk) begin
        bit   resp;
        exp_t e;
        if (!reset_n) begin
            prev_resp = 0;
        end else begin
            resp = bus.phys_valid | bus.berr;
            chk("exclusive", {31'h0, bus.phys_valid & bus.berr}, 32'h0);
            if (resp && !prev_resp) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'h1, 32'h0);
                end else begin
                    e   = q.pop_front();
                    cur = e;
                    chk("berr", {31'h0, bus.berr}, {31'h0, e.err});
                    chk("phys_valid", {31'h0, bus.phys_valid},
                        {31'h0, !e.err});
                    chk("phys_addr", {4'h0, bus.phys_addr}, {4'h0, e.pa});
                    chk("fault_valid", {31'h0, bus.fault_valid},
                        {31'h0, e.fv});
                    chk("fault_addr", {8'h0, bus.fault_addr}, {8'h0, e.fa});
                    chk("latency", cyc, e.due);
                end
            end else if (resp) begin
                chk("phys_addr_hold", {4'h0, bus.phys_addr}, {4'h0, cur.pa});
            end
            prev_resp = resp;
        end
    end

    task automatic pt_write(input logic [6:0] idx, input logic [15:0] d);
        bus.pt_we    = 1'b1;
        bus.pt_addr  = idx;
        bus.pt_wdata = d;
        pt[idx]      = d;
        @(posedge clk);
        @(negedge clk);
        bus.pt_we = 1'b0;
    endtask

    task automatic scramble();
        bus.supervisor_map_1 = 16'($urandom);
        bus.supervisor_map_2 = 16'($urandom);
        bus.user_map         = 4'($urandom);
        bus.addr             = 24'($urandom);
        bus.fc               = 3'($urandom);
        bus.write            = 1'($urandom);
    endtask

    task automatic idle_chk();
        chk("idle_valid", {31'h0, bus.phys_valid}, 32'h0);
        chk("idle_berr", {31'h0, bus.berr}, 32'h0);
        chk("idle_addr", {4'h0, bus.phys_addr}, 32'h0);
    endtask

    // one bus cycle, starting and ending at a falling edge
    task automatic run_cycle(input bit sup, input bit wr,
                             input logic [23:0] a, input logic [2:0] um,
                             input bit clr, input bit drop, input int hold,
                             input bit pt_same);
        logic [28:0] r;
        exp_t        e;
        logic [6:0]  idx;
        idx = {um, a[23:20]};
        r   = model(sup, wr, a, um);
        if (r[28] && (!m_fv || clr)) begin
            m_fv = 1;
            m_fa = a;
        end else if (clr) begin
            m_fv = 0;
        end
        e.err = r[28];
        e.pa  = r[27:0];
        e.fv  = m_fv;
        e.fa  = m_fa;
        e.due = cyc + 3;
        q.push_back(e);
        bus.as       = 1'b1;
        bus.fc       = {sup, 2'($urandom)};
        bus.write    = wr;
        bus.addr     = a;
        bus.user_map = {1'($urandom), um};
        if (pt_same) begin
            bus.pt_we    = 1'b1;
            bus.pt_addr  = idx;
            bus.pt_wdata = 16'($urandom);
            pt[idx]      = bus.pt_wdata;
        end
        @(posedge clk);
        @(negedge clk);
        scramble();
        bus.pt_we    = 1'b1;
        bus.pt_addr  = idx;
        bus.pt_wdata = 16'($urandom);
        pt[idx]      = bus.pt_wdata;
        @(posedge clk);
        @(negedge clk);
        bus.pt_we     = 1'b0;
        bus.fault_clr = clr;
        @(posedge clk);
        @(negedge clk);
        bus.fault_clr = 1'b0;
        for (int i = 0; i < hold; i++) begin
            scramble();
            @(posedge clk);
            @(negedge clk);
        end
        if (drop) begin
            bus.as = 1'b0;
            @(posedge clk);
            @(negedge clk);
            idle_chk();
        end
    endtask

    initial begin
        logic [23:0] a;
        bus.as = 1'b0;
        bus.fc = 3'h0;
        bus.write = 1'b0;
        bus.addr = 24'h0;
        bus.supervisor_map_1 = 16'h0;
        bus.supervisor_map_2 = 16'h0;
        bus.user_map = 4'h0;
        bus.pt_we = 1'b0;
        bus.pt_addr = 7'h0;
        bus.pt_wdata = 16'h0;
        bus.fault_clr = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle_chk();
            chk("reset_fv", {31'h0, bus.fault_valid}, 32'h0);
            @(posedge clk);
            @(negedge clk);
        end

        for (int i = 0; i < 128; i++) begin
            pt_write(7'(i), 16'($urandom));
        end

        bus.supervisor_map_1 = 16'h8012;
        run_cycle(1, 0, 24'hE12345, 3'd0, 0, 1, 2, 0);
        run_cycle(1, 1, 24'h001000, 3'd0, 0, 1, 0, 0);
        bus.supervisor_map_2 = 16'h0000;
        run_cycle(1, 0, 24'hF00000, 3'd0, 0, 1, 1, 0);

        pt_write(7'h13, 16'hC0A5);
        run_cycle(0, 0, 24'h3ABCDE, 3'd1, 0, 1, 3, 0);
        pt_write(7'h13, 16'h80A5);
        run_cycle(0, 1, 24'h3ABCDE, 3'd1, 0, 1, 1, 0);
        pt_write(7'h20, 16'h0000);
        run_cycle(0, 0, 24'h012345, 3'd2, 1, 1, 0, 0);

        bus.fault_clr = 1'b1;
        m_fv = 0;
        @(posedge clk);
        @(negedge clk);
        bus.fault_clr = 1'b0;
        chk("clr_fv", {31'h0, bus.fault_valid}, 32'h0);

        pt_write(7'h45, 16'hC033);
        run_cycle(0, 0, 24'h5FFFFF, 3'd4, 0, 0, 1, 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        idle_chk();
        chk("rst_fv", {31'h0, bus.fault_valid}, 32'h0);
        chk("rst_fa", {8'h0, bus.fault_addr}, 32'h0);
        m_fv = 0;
        m_fa = 24'h0;
        @(negedge clk);
        bus.as = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        pt_write(7'h45, 16'hC077);
        run_cycle(0, 1, 24'h500001, 3'd4, 0, 1, 0, 0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.supervisor_map_1 = {1'($urandom), 15'($urandom)};
                bus.supervisor_map_2 = {1'($urandom), 15'($urandom)};
            end
            a = 24'($urandom);
            if ($urandom_range(0, 2) == 0) a[23:21] = 3'b111;
            run_cycle(1'($urandom), 1'($urandom), a, 3'($urandom),
                      $urandom_range(0, 7) == 0, 1,
                      int'($urandom_range(0, 2)),
                      $urandom_range(0, 7) == 0);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
